// File: rtl/picosoc_pkg.sv
// Shared types and constants for the PicoSoC iomem router.
package picosoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } iomem_state_e;

    // Read data returned when the address decodes to no peripheral
    localparam logic [31:0] MISS_DATA    = 32'hFFFF_FFFF;
    // Read data returned when the selected peripheral never answers
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam int TIMER_W = 16;

endpackage

// File: rtl/iomem_timeout_counter.sv
// Saturating wait-cycle counter with a terminal-count flag.
// tc rises in the cycle whose increment brings the count to TERMINAL,
// so an owner that stops on tc has waited exactly TERMINAL cycles.
module iomem_timeout_counter
    import picosoc_pkg::*;
#(
    parameter int unsigned TERMINAL = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(TERMINAL - 1);

    logic [TIMER_W-1:0] r_cnt;

    // Count while enabled, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset || clear)
            r_cnt <= '0;
        else if (enable && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign tc = (r_cnt >= TC_VAL);

endmodule

// File: rtl/picosoc_iomem_router.sv
// PicoSoC iomem router: decodes one master request onto up to four
// peripherals, waits for the selected ready with a timeout, and keeps a
// sticky record of the first timeout until software clears it.
module picosoc_iomem_router
    import picosoc_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [7:0]  BASE_HI        = 8'h03,
    parameter int          SEL_LSB        = 8,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    input  logic [3:0]                 m_wstrb,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    output logic [31:0]                m_rdata,
    output logic                       m_ready,
    output logic [NUM_SLAVES-1:0]      s_valid,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic                       err_clear,
    output logic                       err_o,
    output logic [1:0]                 err_slave_o,
    output logic [31:0]                err_addr_o
);

    iomem_state_e r_state, w_next;

    logic [31:0] r_addr, r_wdata, r_rdata, r_err_addr;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_idx, r_err_slave;
    logic        r_err;

    logic [1:0]       w_idx_in;
    logic             w_hit, w_start, w_capture, w_timeout, w_tc, w_sel_ready;
    logic [3:0]       w_rdy_pad;
    logic [3:0][31:0] w_rd_pad;

    assign w_idx_in = m_addr[SEL_LSB +: 2];
    assign w_hit    = (m_addr[31:24] == BASE_HI) &&
                      ({30'd0, w_idx_in} < 32'(NUM_SLAVES));

    // Widen the response buses to four ports so the 2-bit index always selects in range
    for (genvar g = 0; g < 4; g++) begin : g_pad
        if (g < NUM_SLAVES) begin : g_on
            assign w_rdy_pad[g] = s_ready[g];
            assign w_rd_pad[g]  = s_rdata[32*g +: 32];
        end else begin : g_off
            assign w_rdy_pad[g] = 1'b0;
            assign w_rd_pad[g]  = '0;
        end
    end

    // Valid drops combinationally on ready so a registered-ready slave sees one strobe
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_sv
        assign s_valid[g] = (r_state == ST_WAIT) && (r_idx == 2'(g)) && !s_ready[g];
    end

    assign w_sel_ready = w_rdy_pad[r_idx];

    iomem_timeout_counter #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_start && w_hit),
        .enable (r_state == ST_WAIT),
        .tc     (w_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next state and datapath strobes; ready beats timeout in the same cycle
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_valid) begin
                    w_start = 1'b1;
                    w_next  = w_hit ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (w_sel_ready) begin
                    w_capture = 1'b1;
                    w_next    = ST_RESP;
                end else if (w_tc) begin
                    w_timeout = 1'b1;
                    w_next    = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Request latch, response data and sticky error record
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_idx       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_slave <= '0;
            r_err_addr  <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= m_addr;
                r_wdata <= m_wdata;
                r_wstrb <= m_wstrb;
                r_idx   <= w_idx_in;
                if (!w_hit)
                    r_rdata <= MISS_DATA;
            end
            if (w_capture)
                r_rdata <= w_rd_pad[r_idx];
            if (w_timeout) begin
                r_rdata <= TIMEOUT_DATA;
                r_err   <= 1'b1;
                // keep the first offender unless this same cycle clears the old one
                if (!r_err || err_clear) begin
                    r_err_slave <= r_idx;
                    r_err_addr  <= r_addr;
                end
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign m_ready     = (r_state == ST_RESP);
    assign m_rdata     = r_rdata;
    assign s_addr      = r_addr;
    assign s_wdata     = r_wdata;
    assign s_wstrb     = r_wstrb;
    assign err_o       = r_err;
    assign err_slave_o = r_err_slave;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_picosoc_iomem_router.sv
// Scoreboard bench for picosoc_iomem_router: behavioural slaves with a
// programmable ready delay, expected read data queued at request time.
module tb_picosoc_iomem_router;

    localparam int NS = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m_valid = 1'b0;
    logic [3:0]        m_wstrb = '0;
    logic [31:0]       m_addr = '0, m_wdata = '0;
    logic [31:0]       m_rdata;
    logic              m_ready;
    logic [NS-1:0]     s_valid;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_addr, s_wdata;
    logic [NS*32-1:0]  s_rdata;
    logic [NS-1:0]     rdy = '0;
    logic              err_clear = 1'b0;
    logic              err_o;
    logic [1:0]        err_slave_o;
    logic [31:0]       err_addr_o;

    logic [3:0][31:0]  sl_data;
    int                sl_delay [4];
    int                sl_cnt   [4];
    logic [3:0]        sl_busy = '0;
    logic [3:0]        sv_neg = '0;
    int                vcnt [4];
    int                wcnt [4];

    logic [31:0]       sb_q [$];
    logic [31:0]       exp_addr, exp_wdata;
    int                errs = 0;
    int                checks = 0;

    assign s_rdata = sl_data;

    picosoc_iomem_router #(
        .NUM_SLAVES     (NS),
        .BASE_HI        (8'h03),
        .SEL_LSB        (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_wstrb     (m_wstrb),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .s_valid     (s_valid),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_ready     (rdy),
        .err_clear   (err_clear),
        .err_o       (err_o),
        .err_slave_o (err_slave_o),
        .err_addr_o  (err_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave side observation at mid-cycle: valid counts and request stability
    always @(negedge clk) begin
        sv_neg <= s_valid;
        for (int i = 0; i < NS; i++) begin
            if (s_valid[i]) begin
                vcnt[i]++;
                if (s_wstrb != 4'h0) wcnt[i]++;
            end
        end
        if (|s_valid) begin
            chk("s_addr", s_addr, exp_addr);
            chk("s_wdata", s_wdata, exp_wdata);
        end
    end

    // Scoreboard: every m_ready pulse consumes one expected read value
    always @(negedge clk) begin
        if (m_ready) begin
            if (sb_q.size() == 0)
                chk("spurious_m_ready", 32'(m_ready), 32'd0);
            else
                chk("m_rdata", m_rdata, sb_q.pop_front());
        end
    end

    // Registered slaves: ready pulses sl_delay cycles after the first valid seen
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (reset) begin
                rdy[i]     <= 1'b0;
                sl_busy[i] <= 1'b0;
            end else if (rdy[i]) begin
                rdy[i] <= 1'b0;
            end else if (sl_busy[i]) begin
                if (sl_cnt[i] <= 1) begin
                    rdy[i]     <= 1'b1;
                    sl_busy[i] <= 1'b0;
                end else begin
                    sl_cnt[i] <= sl_cnt[i] - 1;
                end
            end else if (sv_neg[i] && sl_delay[i] > 0) begin
                if (sl_delay[i] == 1) begin
                    rdy[i] <= 1'b1;
                end else begin
                    sl_busy[i] <= 1'b1;
                    sl_cnt[i]  <= sl_delay[i] - 1;
                end
            end
        end
    end

    // One master transaction; clr_at pulses err_clear on that cycle index
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_data,
                          input int exp_lat, input int clr_at);
        int n;
        bit got;
        sb_q.push_back(exp_data);
        exp_addr  = addr;
        exp_wdata = wdata;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        n = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            err_clear = (n == clr_at);
            if (m_ready) got = 1'b1;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        @(negedge clk);
        m_valid   = 1'b0;
        err_clear = 1'b0;
        chk("m_ready_one_cycle", 32'(m_ready), 32'd0);
    endtask

    initial begin
        int v_before;
        for (int i = 0; i < 4; i++) begin
            sl_delay[i] = 0; sl_cnt[i] = 0; vcnt[i] = 0; wcnt[i] = 0;
        end
        sl_data[0] = 32'h0000_1000;
        sl_data[1] = 32'h1111_0001;
        sl_data[2] = 32'h0000_00A5;
        sl_data[3] = 32'h3333_0003;
        exp_addr = '0; exp_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_err", {err_o, 29'd0, err_slave_o}, 32'd0);
        chk("rst_err_addr", err_addr_o, 32'd0);
        reset = 1'b0;

        // registered-ready write to slave 1: one strobe, m_ready 3 cycles on
        sl_delay[1] = 1;
        do_txn(32'h0300_0104, 32'h1, 4'hF, sl_data[1], 3, 0);
        chk("s1_valid_cycles", 32'(vcnt[1]), 32'd1);
        chk("s1_writes", 32'(wcnt[1]), 32'd1);

        // slave 2 answers after 5 cycles
        sl_delay[2] = 5;
        do_txn(32'h0300_0200, 32'h0, 4'h0, 32'h0000_00A5, 7, 0);
        chk("s2_err", 32'(err_o), 32'd0);

        // decode miss: no slave touched
        v_before = vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3];
        do_txn(32'h0400_0000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1, 0);
        chk("miss_no_valid", 32'(vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3]), 32'(v_before));

        // slave 0 after 2 cycles
        sl_delay[0] = 2;
        do_txn(32'h0300_0000, 32'h0, 4'h0, sl_data[0], 4, 0);

        // slave 3 never ready: timeout and sticky record
        sl_delay[3] = 0;
        do_txn(32'h0300_0300, 32'h0, 4'h0, 32'hDEAD_BEEF, TO + 1, 0);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_err_slave", 32'(err_slave_o), 32'd3);
        chk("to_err_addr", err_addr_o, 32'h0300_0300);

        // second timeout keeps first record; late ready in RESP is ignored
        sl_delay[0] = TO;
        do_txn(32'h0300_0004, 32'h0, 4'h0, 32'hDEAD_BEEF, TO + 1, 0);
        chk("to2_err_slave", 32'(err_slave_o), 32'd3);
        chk("to2_err_addr", err_addr_o, 32'h0300_0300);

        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        chk("clr_err", 32'(err_o), 32'd0);

        // ready on the timeout cycle wins
        sl_delay[2] = TO - 1;
        sl_data[2]  = 32'h5A5A_0002;
        do_txn(32'h0300_0200, 32'h0, 4'h0, 32'h5A5A_0002, TO + 1, 0);
        chk("race_err", 32'(err_o), 32'd0);

        // timeout concurrent with err_clear: new record wins
        sl_delay[1] = 0;
        do_txn(32'h0300_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, TO + 1, 0);
        chk("to3_err_slave", 32'(err_slave_o), 32'd1);
        do_txn(32'h0300_0310, 32'h0, 4'h0, 32'hDEAD_BEEF, TO + 1, TO);
        chk("clr_race_err", 32'(err_o), 32'd1);
        chk("clr_race_slave", 32'(err_slave_o), 32'd3);
        chk("clr_race_addr", err_addr_o, 32'h0300_0310);

        // reset on the second WAIT cycle aborts silently
        sl_delay[1] = 5;
        exp_addr = 32'h0300_0104;
        exp_wdata = 32'h77;
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0300_0104; m_wdata = 32'h77; m_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("abort_valid_pre", 32'(s_valid), 32'h2);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_s_valid", 32'(s_valid), 32'd0);
        chk("abort_m_ready", 32'(m_ready), 32'd0);
        chk("abort_m_rdata", m_rdata, 32'd0);
        chk("abort_err", 32'(err_o), 32'd0);
        m_valid = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // normal transaction after the abort
        sl_delay[1] = 1;
        v_before = vcnt[1];
        do_txn(32'h0300_0104, 32'h1, 4'hF, sl_data[1], 3, 0);
        chk("post_abort_valid", 32'(vcnt[1] - v_before), 32'd1);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/picosoc_iomem_router.md
PICOSOC_IOMEM_ROUTER -- requirements
Module: picosoc_iomem_router

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, meaning number of peripheral ports (1..4).
REQ-002 SHALL have parameter BASE_HI, default 8'h03, meaning required value of m_addr[31:24] for a decode hit.
REQ-003 SHALL have parameter SEL_LSB, default 8, meaning the LSB of the 2-bit slave-select field m_addr[SEL_LSB+1:SEL_LSB].
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum cycles to wait for a slave ready (1..65535).
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports m_valid (in, 1), m_wstrb (in, 4), m_addr (in, 32), m_wdata (in, 32), m_rdata (out, 32) and m_ready (out, 1), forming the PicoSoC iomem master side.
REQ-008 SHALL have ports s_valid (out, NUM_SLAVES), s_wstrb (out, 4), s_addr (out, 32) and s_wdata (out, 32), forming the broadcast slave request.
REQ-009 SHALL have ports s_rdata (in, NUM_SLAVES×32, packed, slave i at [32i+31:32i]) and s_ready (in, NUM_SLAVES), forming the slave responses.
REQ-010 SHALL have port err_clear (in, 1): clears the sticky error.
REQ-011 SHALL have ports err_o (out, 1), err_slave_o (out, 2) and err_addr_o (out, 32): sticky timeout flag, offending slave index and offending address.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 In IDLE with m_valid=1, SHALL latch m_addr, m_wdata, m_wstrb and select index; a hit (m_addr[31:24]==BASE_HI and index<NUM_SLAVES) goes to WAIT and clears the timer.
REQ-014 In IDLE with m_valid=1 and a miss, SHALL load m_rdata=32'hFFFF_FFFF, go to RESP and touch no slave.
REQ-015 s_addr/s_wdata/s_wstrb SHALL be the latched values, stable for the whole of WAIT.
REQ-016 s_valid[i] SHALL be 1 only when state==WAIT, i==latched index and s_ready[i]==0 (combinational drop), so a slave that registers ready one cycle after valid sees exactly one valid cycle.
REQ-017 In WAIT with s_ready[idx]=1, SHALL capture s_rdata[idx] into m_rdata and go to RESP.
REQ-018 In WAIT, the timer SHALL increment each cycle; on reaching TIMEOUT_CYCLES without ready, SHALL load m_rdata=32'hDEAD_BEEF, set err_o, record err_slave_o/err_addr_o, and go to RESP.
REQ-019 If ready and timeout occur in the same cycle, ready SHALL win: data is captured and no error is raised.
REQ-020 In RESP, m_ready SHALL be 1 for exactly one cycle with m_rdata valid; the next state SHALL be IDLE unconditionally.
REQ-021 m_ready SHALL be 0 in IDLE and WAIT; m_rdata SHALL hold its last value outside RESP.
REQ-022 s_ready/s_rdata from non-selected slaves, or any s_ready seen in IDLE/RESP, SHALL be ignored.
REQ-023 Latency: hit with slave ready k cycles after WAIT entry gives m_ready k+2 cycles after m_valid sampled; miss gives m_ready 1 cycle after m_valid sampled.
REQ-024 err_o, once set, SHALL stay set until err_clear; err_clear in IDLE/WAIT/RESP SHALL clear err_o; a new timeout in the same cycle as err_clear SHALL win (flag set, new index/address).
REQ-025 A later timeout while err_o=1 SHALL NOT overwrite err_slave_o/err_addr_o.
REQ-026 The timer SHALL be 16 bits and saturate; there SHALL be no wrap-around.

Reset
REQ-027 On reset=1 at a clk edge: state=IDLE, m_ready=0, m_rdata=0, s_valid=0, latched addr/wdata/wstrb=0, timer=0, err_o=0, err_slave_o=0, err_addr_o=0.
REQ-028 Reset mid-WAIT SHALL abort without an m_ready pulse; s_valid SHALL be 0 in the cycle after the reset edge.

Structure
REQ-029 State enum, MISS_DATA (32'hFFFF_FFFF) and TIMEOUT_DATA (32'hDEAD_BEEF) SHALL live in shared package picosoc_pkg.
REQ-030 The timeout counter SHALL be a sub-module, iomem_timeout_counter (clear, enable, terminal count output).

Verification
REQ-031 Write to 0x0300_0104 with data 0x1, wstrb=4'hF, and slave 1 registering ready 1 cycle after valid -> s_valid[1] high exactly 1 cycle, m_ready 3 cycles after request, slave sees one write.
REQ-032 Read from 0x0300_0200 with slave 2 returning 0x0000_00A5 after 5 cycles -> m_rdata=0x0000_00A5 on the m_ready cycle, err_o=0.
REQ-033 Read from 0x0400_0000 -> no s_valid, m_ready 1 cycle later, m_rdata=0xFFFF_FFFF.
REQ-034 Slave 3 never ready, TIMEOUT_CYCLES=8 -> m_ready after timeout with m_rdata=0xDEAD_BEEF, err_o=1, err_slave_o=3, err_addr_o=0x0300_0300; err_clear -> err_o=0.
REQ-035 Ready exactly on the timeout cycle -> slave data returned, err_o=0.
REQ-036 Reset asserted on the 2nd WAIT cycle -> no m_ready, s_valid=0 next cycle; the next transaction completes normally.
